// File: rtl/blob_frame_gen.sv
// Synthetic 640x480 grey-level frame source with one programmable bright rectangle.
// Define BLOB_FRAME_NOISE_EN to add LFSR noise to the background level.
module blob_frame_gen #(
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter int          H_BLANK  = 160,
   parameter int          V_BLANK  = 45,
   parameter logic [11:0] BG_LEVEL = 12'h100,
   parameter logic [11:0] FG_LEVEL = 12'hFFF
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iStart,
   input  logic        iCont,
   input  logic        iStop,
   input  logic        iReady,
   input  logic [10:0] iBoxX,
   input  logic [10:0] iBoxY,
   input  logic [10:0] iBoxW,
   input  logic [10:0] iBoxH,
   output logic [11:0] oColor,
   output logic        oDVAL,
   output logic [10:0] oX,
   output logic [10:0] oY,
   output logic        oFrameStart,
   output logic        oFrameEnd,
   output logic        oBusy
);

   localparam int LINE_CYC = H_ACTIVE + H_BLANK;
   localparam int VB_CYC   = V_BLANK * LINE_CYC;
   localparam int CNT_W    = (VB_CYC > H_BLANK) ? $clog2(VB_CYC + 1) : $clog2(H_BLANK + 1);
   localparam logic [10:0]      X_LAST    = 11'(H_ACTIVE - 1);
   localparam logic [10:0]      Y_LAST    = 11'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] VB_LAST   = CNT_W'(VB_CYC - 1);
   localparam logic             ONE_PIXEL = (H_ACTIVE == 1) && (V_ACTIVE == 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} stateT;

   stateT            state;
   logic [CNT_W-1:0] blankCnt;
   logic [10:0]      boxX, boxY, boxW, boxH;
   logic             contFlag;
   logic             stopPending;
   logic [10:0]      xNext, yNext;
   logic [11:0]      bgCur, bgAdv;

   assign xNext = oX + 11'd1;
   assign yNext = oY + 11'd1;

   // Upper bound evaluated one bit wider so a box running off the frame never wraps.
   function automatic logic inSpan(input logic [10:0] pos, input logic [10:0] lo,
                                   input logic [10:0] len);
      logic [11:0] hi;
      hi = {1'b0, lo} + {1'b0, len};
      return (pos >= lo) && ({1'b0, pos} < hi);
   endfunction

   function automatic logic [11:0] pixColor(input logic [10:0] x, input logic [10:0] y,
                                            input logic [10:0] bx, input logic [10:0] by,
                                            input logic [10:0] bw, input logic [10:0] bh,
                                            input logic [11:0] bg);
      return (inSpan(x, bx, bw) && inSpan(y, by, bh)) ? FG_LEVEL : bg;
   endfunction

`ifdef BLOB_FRAME_NOISE_EN
   logic [15:0] lfsr;
   logic [15:0] lfsrAdv;

   assign lfsrAdv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   function automatic logic [11:0] noisyBg(input logic [7:0] n);
      logic [12:0] s;
      s = {1'b0, BG_LEVEL} + {5'd0, n};
      return s[12] ? 12'hFFF : s[11:0];
   endfunction

   // bgAdv serves the pixel presented right after an acceptance, when the LFSR steps.
   assign bgCur = noisyBg(lfsr[7:0]);
   assign bgAdv = noisyBg(lfsrAdv[7:0]);

   always_ff @(posedge iCLK) begin
      if (iRST)
         lfsr <= 16'hACE1;
      else if (state == ACTIVE && iReady)
         lfsr <= lfsrAdv;
   end
`else
   assign bgCur = BG_LEVEL;
   assign bgAdv = BG_LEVEL;
`endif

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state       <= IDLE;
         blankCnt    <= '0;
         boxX        <= '0;
         boxY        <= '0;
         boxW        <= '0;
         boxH        <= '0;
         contFlag    <= 1'b0;
         stopPending <= 1'b0;
         oColor      <= '0;
         oDVAL       <= 1'b0;
         oX          <= '0;
         oY          <= '0;
         oFrameStart <= 1'b0;
         oFrameEnd   <= 1'b0;
         oBusy       <= 1'b0;
      end else begin
         if (state != IDLE && iStop)
            stopPending <= 1'b1;
         case (state)
            IDLE: begin
               if (iStart) begin
                  boxX        <= iBoxX;
                  boxY        <= iBoxY;
                  boxW        <= iBoxW;
                  boxH        <= iBoxH;
                  contFlag    <= iCont & ~iStop;
                  stopPending <= 1'b0;
                  state       <= ACTIVE;
                  oBusy       <= 1'b1;
                  oDVAL       <= 1'b1;
                  oX          <= '0;
                  oY          <= '0;
                  oColor      <= pixColor(11'd0, 11'd0, iBoxX, iBoxY, iBoxW, iBoxH, bgCur);
                  oFrameStart <= 1'b1;
                  oFrameEnd   <= ONE_PIXEL;
               end
            end
            ACTIVE: begin
               if (iReady) begin
                  oFrameStart <= 1'b0;
                  oFrameEnd   <= 1'b0;
                  if (oX != X_LAST) begin
                     oX        <= xNext;
                     oColor    <= pixColor(xNext, oY, boxX, boxY, boxW, boxH, bgAdv);
                     oFrameEnd <= (xNext == X_LAST) && (oY == Y_LAST);
                  end else begin
                     // The last line goes straight into vertical blanking.
                     state    <= (oY == Y_LAST) ? VBLANK : HBLANK;
                     blankCnt <= '0;
                     oDVAL    <= 1'b0;
                     oColor   <= '0;
                  end
               end
            end
            HBLANK: begin
               if (iReady) begin
                  if (blankCnt == HB_LAST) begin
                     state     <= ACTIVE;
                     oDVAL     <= 1'b1;
                     oX        <= '0;
                     oY        <= yNext;
                     oColor    <= pixColor(11'd0, yNext, boxX, boxY, boxW, boxH, bgCur);
                     oFrameEnd <= (X_LAST == 11'd0) && (yNext == Y_LAST);
                  end else begin
                     blankCnt <= blankCnt + 1'b1;
                  end
               end
            end
            VBLANK: begin
               if (iReady) begin
                  if (blankCnt != VB_LAST) begin
                     blankCnt <= blankCnt + 1'b1;
                  end else if (contFlag && !stopPending && !iStop) begin
                     boxX        <= iBoxX;
                     boxY        <= iBoxY;
                     boxW        <= iBoxW;
                     boxH        <= iBoxH;
                     state       <= ACTIVE;
                     oDVAL       <= 1'b1;
                     oX          <= '0;
                     oY          <= '0;
                     oColor      <= pixColor(11'd0, 11'd0, iBoxX, iBoxY, iBoxW, iBoxH, bgCur);
                     oFrameStart <= 1'b1;
                     oFrameEnd   <= ONE_PIXEL;
                  end else begin
                     state       <= IDLE;
                     oBusy       <= 1'b0;
                     oX          <= '0;
                     oY          <= '0;
                     contFlag    <= 1'b0;
                     stopPending <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/blob_frame_gen.md
Name: blob_frame_gen

Overview:
- Synthetic camera-side pixel source: emits a raster-scanned 640x480 grey-level frame on a valid-qualified pixel stream.
- The frame holds one bright rectangle ("blob") on a dark background.
- Drives the centroid/group detection path in simulation and on-board bring-up, in place of the camera front end.
- Blob position/size programmable per frame, so detected centroid can be checked against a known answer.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_BLANK, 160, idle cycles after each line
V_BLANK, 45, idle lines (each H_ACTIVE+H_BLANK cycles) after frame
BG_LEVEL, 12'h100, background pixel value
FG_LEVEL, 12'hFFF, blob pixel value

Ports:
iCLK  in  1  clock; all logic on rising edge
iRST  in  1  reset, synchronous, active-high
iStart  in  1  pulse: begin frame(s) when idle
iCont  in  1  1 = free-run frames until iStop; sampled with iStart
iStop  in  1  pulse: finish current frame incl. V blank, then idle
iReady  in  1  downstream accept; 0 freezes generator
iBoxX  in  11  blob left column
iBoxY  in  11  blob top row
iBoxW  in  11  blob width in pixels
iBoxH  in  11  blob height in lines
oColor  out  12  pixel value, valid when oDVAL
oDVAL  out  1  active-pixel strobe
oX  out  11  column of current pixel
oY  out  11  row of current pixel
oFrameStart  out  1  with pixel (0,0)
oFrameEnd  out  1  with pixel (H_ACTIVE-1,V_ACTIVE-1)
oBusy  out  1  state != IDLE

Behaviour:
- Reset (iRST=1 at edge): state IDLE; oColor=0, oDVAL=0, oX=0, oY=0, oFrameStart=0, oFrameEnd=0, oBusy=0; latched box and continuous flag cleared. Reset mid-frame aborts immediately; no partial-frame completion.
- States:
  - IDLE: all outputs 0 except oX/oY, which hold 0. iStart=1 -> latch iBox*, iCont; next cycle ACTIVE at (0,0).
  - ACTIVE: one pixel per cycle with iReady=1. oX increments 0..H_ACTIVE-1, then HBLANK. After the last pixel of line V_ACTIVE-1 -> VBLANK (no HBLANK on the final line).
  - HBLANK: H_BLANK cycles, oDVAL=0; then ACTIVE at (0, oY+1).
  - VBLANK: V_BLANK*(H_ACTIVE+H_BLANK) cycles, oDVAL=0. At end:
    - continuous flag set and no stop pending -> re-latch iBox*, ACTIVE at (0,0).
    - otherwise -> IDLE.
- Outputs registered; oColor/oX/oY/oDVAL/strobes all refer to the same pixel in the same cycle.
- Pixel value: FG_LEVEL iff iBoxX <= x < iBoxX+iBoxW and iBoxY <= y < iBoxY+iBoxH (latched values); else BG_LEVEL.
  - Sums computed at 12 bits; no wrap.
  - Box extending past frame edge clipped.
  - W=0 or H=0 -> no FG pixels.
- Box inputs changed mid-frame have no effect until the next frame latch.
- iReady=0: all counters, state and outputs hold, including blanking counters. oDVAL stays high if it was high; the pixel repeats until accepted.
- iStart while busy: ignored.
- iStop:
  - Sets stop-pending, cleared on entry to IDLE.
  - Current frame completes normally.
  - iStop in IDLE is ignored.
  - iStop and iStart in the same IDLE cycle: start wins with continuous flag forced 0 (single frame).
- oFrameStart/oFrameEnd: one-pixel pulses, high only while oDVAL=1 at the stated pixels. Held, not repeated, under iReady=0.
- Frame period with iReady=1: V_ACTIVE*(H_ACTIVE+H_BLANK) - H_BLANK + V_BLANK*(H_ACTIVE+H_BLANK) cycles.

Optional Feature:
- Macro BLOB_FRAME_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 at reset.
  - Advances on each accepted active pixel.
  - Low 8 bits added to BG_LEVEL for background pixels, saturating at 12'hFFF.
  - Blob pixels unaffected.
  - Exercises detector threshold with non-flat background.
- Undefined: background constant BG_LEVEL; no LFSR logic.

Test Plan:
- Reset mid-ACTIVE at (100,50) -> next cycle all outputs 0, oBusy=0; later iStart restarts at (0,0).
- iStart, iCont=0, box (200,100,40,20), iReady=1:
  - exactly 307200 oDVAL cycles;
  - FG count 800, FG exactly at x 200..239, y 100..119;
  - oFrameEnd at (639,479); oBusy drops after VBLANK.
- Box (620,470,50,50) -> clipped: FG count 20*10=200; no oX>639 or oY>479.
- Box W=0 -> zero FG pixels; frame length unchanged.
- iCont=1, box changed mid-frame to (10,10,4,4):
  - frame 1 uses old box, frame 2 new box (FG count 16);
  - iStop during frame 2 -> oBusy low after frame 2 VBLANK, no frame 3.
- Random iReady (50% low): pixel sequence identical to iReady=1 run; oX/oY/oColor held stable while iReady=0; oFrameStart seen once per frame.
